// File: rtl/stream_mac_loopback_if.sv
// ---------------------------------------------------------------------------
// stream_mac_loopback_if
//   Valid/ready stream bundle shared by the host-to-card and card-to-host
//   sides of the loopback kernels.
//
//   Signals:
//     valid  producer has a beat on data
//     rdy    consumer can take the beat; a transfer happens on valid && rdy
//     data   DATA_W-bit beat payload
//
//   Modports:
//     master  drives valid/data, observes rdy   (stream source)
//     slave   observes valid/data, drives rdy   (stream sink)
// ---------------------------------------------------------------------------
interface stream_mac_loopback_if #(
    parameter int DATA_W = 128
) ();
    logic              valid;
    logic              rdy;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input rdy);
    modport slave  (input valid, input data, output rdy);
endinterface

// File: rtl/stream_mac_loopback.sv
// ---------------------------------------------------------------------------
// stream_mac_loopback
//   Lane-wise 32x32 multiply-accumulate kernel placed between the stream
//   input and output endpoints. Each input beat carries LANES operand pairs
//   (lane i: a = data[64i+63:64i+32], b = data[64i+31:64i]). Depending on the
//   mode the block echoes the beat (PASS), returns the sum of lane products
//   for every beat (DOT), or sums that value over a block of blk_len beats
//   (REDUCE). Results sit in a first-word-fall-through FIFO until the
//   card-to-host side accepts them.
//
//   Result beat layout for DOT/REDUCE:
//     [31:0]  dot value or accumulated sum (mod 2^32)
//     [63:32] data[31:0] of the last beat that contributed
//     [95:64] sequence number of the output beat
//     others  SIG
//
//   Ports:
//     clk         clock for all logic
//     rst         synchronous, active-low reset
//     s1i         host-to-card stream (slave side)
//     s1o         card-to-host stream (master side)
//     mode        0/3 = PASS, 1 = DOT, 2 = REDUCE
//     blk_len     beats per REDUCE block (0 behaves as 1)
//     fifo_level  occupied output FIFO entries
//     busy        work is pending somewhere in the block
// ---------------------------------------------------------------------------
module stream_mac_loopback #(
    parameter int          DATA_W = 128,
    parameter int          DEPTH  = 16,
    parameter logic [31:0] SIG    = 32'h42424242
) (
    input  logic                      clk,
    input  logic                      rst,
    stream_mac_loopback_if.slave      s1i,
    stream_mac_loopback_if.master     s1o,
    input  logic [1:0]                mode,
    input  logic [15:0]               blk_len,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      busy
);

    localparam int LANES = DATA_W / 64;
    localparam int WORDS = DATA_W / 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_DOT      = 2'd1,
        MODE_REDUCE   = 2'd2,
        MODE_PASS_ALT = 2'd3
    } mode_t;

    function automatic logic is_pass(input mode_t m);
        return (m == MODE_PASS) || (m == MODE_PASS_ALT);
    endfunction

    // ------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------
    logic          in_rdy;
    logic          in_fire;
    logic [LW:0]   occupancy;

    // Stage-1 / stage-2 control (declared early, used by the credit check)
    logic          s1_valid;
    logic          s1_first;
    logic          s1_emit;
    logic          s1_pass;
    logic          s2_valid;
    logic          s2_pass;

    logic [LW-1:0] level_q;

    // Beats that will still land in the FIFO are counted against DEPTH so an
    // accepted beat always finds a free entry. Only registers feed this, so
    // there is no combinational path from s1o.rdy to s1i.rdy.
    assign occupancy = {1'b0, level_q}
                     + (LW+1)'(s1_valid && s1_emit)
                     + (LW+1)'(s2_valid);
    assign in_rdy    = occupancy < (LW+1)'(DEPTH);
    assign in_fire   = s1i.valid && in_rdy;
    assign s1i.rdy   = in_rdy;

    // ------------------------------------------------------------------
    // Block FSM: decides, at acceptance time, whether a beat starts a new
    // sum and whether it completes a result.
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    mode_t       mode_q,  mode_d;
    logic [15:0] len_q,   len_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [15:0] eff_len;
    logic        beat_first;
    logic        beat_emit;
    logic        beat_pass;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_PASS;
            len_q   <= 16'd1;
            cnt_q   <= 16'd0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        beat_first = 1'b0;
        beat_emit  = 1'b0;
        beat_pass  = 1'b0;
        eff_len    = (blk_len == 16'd0) ? 16'd1 : blk_len;

        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    mode_d     = mode_t'(mode);
                    len_d      = eff_len;
                    beat_first = 1'b1;
                    beat_pass  = is_pass(mode_t'(mode));
                    if ((mode_t'(mode) == MODE_REDUCE) && (eff_len > 16'd1)) begin
                        cnt_d   = 16'd1;
                        state_d = ST_ACCUM;
                    end else begin
                        beat_emit = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                // mode/blk_len inputs are deliberately not looked at here;
                // the block finishes with the values latched at its start.
                if (in_fire) begin
                    beat_pass = is_pass(mode_q);
                    if (cnt_q + 16'd1 == len_q) begin
                        beat_emit = 1'b1;
                        cnt_d     = 16'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: lane products, low data word and beat tags
    // ------------------------------------------------------------------
    logic [31:0]       s1_prod [LANES];
    logic [31:0]       s1_lo;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_emit  <= 1'b0;
            s1_pass  <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_first <= beat_first;
                s1_emit  <= beat_emit;
                s1_pass  <= beat_pass;
            end
        end
    end

    // Pure datapath: only ever consumed under s1_valid.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= s1i.data[64*i+32 +: 32] * s1i.data[64*i +: 32];
            end
            s1_lo   <= s1i.data[31:0];
            s1_data <= s1i.data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: dot value, accumulator and result word
    // ------------------------------------------------------------------
    logic [31:0]       dot;
    logic [31:0]       acc_q;
    logic [31:0]       acc_sum;
    logic [DATA_W-1:0] result_word;
    logic [DATA_W-1:0] s2_word;

    always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++) begin
            dot = dot + s1_prod[i];
        end
        // A block's first beat replaces the running sum instead of adding.
        acc_sum = s1_first ? dot : (acc_q + dot);
    end

    // The sequence field is left zero here and filled in on the FIFO write,
    // where the counter is exact for this beat.
    always_comb begin
        result_word = '0;
        for (int w = 3; w < WORDS; w++) begin
            result_word[32*w +: 32] = SIG;
        end
        result_word[63:32] = s1_lo;
        result_word[31:0]  = acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_pass  <= 1'b0;
            acc_q    <= '0;
        end else begin
            s2_valid <= s1_valid && s1_emit;
            if (s1_valid) begin
                s2_pass <= s1_pass;
                acc_q   <= s1_emit ? 32'd0 : acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid && s1_emit) begin
            s2_word <= s1_pass ? s1_data : result_word;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through) and sequence counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [31:0]       seq_q;
    logic              fifo_we;
    logic              fifo_re;
    logic [DATA_W-1:0] fifo_wdata;

    assign fifo_we = s2_valid;
    assign fifo_re = (level_q != '0) && s1o.rdy;

    always_comb begin
        fifo_wdata = s2_word;
        if (!s2_pass) begin
            fifo_wdata[95:64] = seq_q;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
        end else begin
            if (fifo_we) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                seq_q    <= seq_q + 32'd1;
            end
            if (fifo_re) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({fifo_we, fifo_re})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only visible once level_q
    // covers it, and clearing the pointers discards everything it holds.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem[wr_ptr_q] <= fifo_wdata;
        end
    end

    assign s1o.valid  = (level_q != '0);
    assign s1o.data   = mem[rd_ptr_q];
    assign fifo_level = level_q;
    assign busy       = (state_q != ST_IDLE) || s1_valid || s2_valid
                        || (level_q != '0);

endmodule

// File: tb/tb_stream_mac_loopback.sv
// ---------------------------------------------------------------------------
// tb_stream_mac_loopback
//   Directed bench for stream_mac_loopback (DATA_W=128, DEPTH=16). Inputs are
//   driven 1 time unit after the rising edge; outputs are observed on the
//   falling edge, where the output monitor also records each transfer.
// ---------------------------------------------------------------------------
module tb_stream_mac_loopback;

    localparam logic [31:0] SIG = 32'h42424242;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [15:0] blk_len;
    logic [4:0]  fifo_level;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int first_acc = -1;
    int first_val = -1;
    logic [127:0] got_q [$];

    // Standard DOT operand beat: lanes (3,4) and (5,6) -> 12 + 30 = 0x2A.
    localparam logic [127:0] D_BEAT = {32'd3, 32'd4, 32'd5, 32'd6};

    stream_mac_loopback_if #(.DATA_W(128)) s1i_if ();
    stream_mac_loopback_if #(.DATA_W(128)) s1o_if ();

    stream_mac_loopback #(
        .DATA_W (128),
        .DEPTH  (16),
        .SIG    (SIG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s1i        (s1i_if),
        .s1o        (s1o_if),
        .mode       (mode),
        .blk_len    (blk_len),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (s1o_if.valid && s1o_if.rdy) got_q.push_back(s1o_if.data);
            if (s1i_if.valid && s1i_if.rdy && first_acc < 0) first_acc = cyc;
            if (s1o_if.valid && first_val < 0) first_val = cyc;
        end
    end

    function automatic logic [127:0] exp_word(input logic [31:0] seq,
                                               input logic [31:0] lo,
                                               input logic [31:0] val);
        return {SIG, seq, lo, val};
    endfunction

    // Operands (k,1) and (2,k): dot = 3k, low word = k.
    function automatic logic [127:0] bp_word(input int k);
        return {32'(k), 32'd1, 32'd2, 32'(k)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    task automatic send_beat(input logic [127:0] d);
        bit done = 1'b0;
        s1i_if.valid = 1'b1;
        s1i_if.data  = d;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (s1i_if.rdy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s1i_if.valid = 1'b0;
        if (!done) check("send_timeout", 128'(done), 128'(1));
    endtask

    task automatic wait_out(input string tag, input int target);
        for (int c = 0; c < 400 && got_q.size() < target; c++) tick(1);
        check(tag, 128'(got_q.size() >= target), 128'(1));
    endtask

    initial begin
        int base;
        int sent;

        rst          = 1'b0;
        mode         = 2'd0;
        blk_len      = 16'd0;
        s1i_if.valid = 1'b0;
        s1i_if.data  = '0;
        s1o_if.rdy   = 1'b1;

        // ---------------- reset state ----------------
        tick(2);
        check("rst_s1o_valid", 128'(s1o_if.valid), 128'(0));
        check("rst_level",     128'(fifo_level),   128'(0));
        check("rst_busy",      128'(busy),         128'(0));
        rst = 1'b1;
        tick(1);
        check("rst_s1i_rdy",   128'(s1i_if.rdy),   128'(1));

        // ---------------- PASS, 8 beats back to back ----------------
        base = got_q.size();
        mode = 2'd0;
        for (int i = 0; i < 8; i++) send_beat(128'(i));
        wait_out("pass_wait", base + 8);
        for (int i = 0; i < 8; i++) check($sformatf("pass_beat%0d", i), got_q[base+i], 128'(i));
        check("pass_latency", 128'(first_val - first_acc), 128'(3));

        // mode 3 is also PASS
        base = got_q.size();
        mode = 2'd3;
        send_beat(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        wait_out("pass3_wait", base + 1);
        check("pass3_beat", got_q[base], 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

        // ---------------- DOT ----------------
        do_reset();
        base = got_q.size();
        mode = 2'd1;
        send_beat(D_BEAT);
        send_beat(D_BEAT);
        wait_out("dot_wait", base + 2);
        check("dot_beat0", got_q[base],   exp_word(32'd0, 32'd6, 32'h2A));
        check("dot_beat1", got_q[base+1], exp_word(32'd1, 32'd6, 32'h2A));

        // ---------------- REDUCE, blk_len=4 ----------------
        base    = got_q.size();
        mode    = 2'd2;
        blk_len = 16'd4;
        for (int i = 0; i < 4; i++) send_beat(D_BEAT);
        wait_out("red4_wait", base + 1);
        tick(8);
        check("red4_count", 128'(got_q.size() - base), 128'(1));
        check("red4_beat",  got_q[base], exp_word(32'd2, 32'd6, 32'hA8));
        check("red4_idle_busy", 128'(busy), 128'(0));

        // REDUCE with blk_len=0 behaves as one beat per block
        base    = got_q.size();
        blk_len = 16'd0;
        send_beat(D_BEAT);
        send_beat(D_BEAT);
        wait_out("red0_wait", base + 2);
        tick(6);
        check("red0_count", 128'(got_q.size() - base), 128'(2));
        check("red0_beat0", got_q[base],   exp_word(32'd3, 32'd6, 32'h2A));
        check("red0_beat1", got_q[base+1], exp_word(32'd4, 32'd6, 32'h2A));

        // ---------------- backpressure: fill to DEPTH ----------------
        do_reset();
        base       = got_q.size();
        mode       = 2'd1;
        s1o_if.rdy = 1'b0;
        sent       = 0;
        for (int c = 0; c < 40; c++) begin
            s1i_if.data  = bp_word(sent);
            s1i_if.valid = 1'b1;
            @(negedge clk);
            if (s1i_if.rdy) sent++;
            @(posedge clk);
            #1;
        end
        s1i_if.valid = 1'b0;
        check("bp_accepted", 128'(sent),       128'(16));
        check("bp_level",    128'(fifo_level), 128'(16));
        check("bp_rdy_low",  128'(s1i_if.rdy), 128'(0));
        check("bp_busy",     128'(busy),       128'(1));
        s1o_if.rdy = 1'b1;
        wait_out("bp_drain_wait", base + 16);
        for (int k = 0; k < 16; k++)
            check($sformatf("bp_beat%0d", k), got_q[base+k],
                  exp_word(32'(k), 32'(k), 32'(3*k)));
        tick(2);
        check("bp_level_empty", 128'(fifo_level), 128'(0));

        // ---------------- random output stalls ----------------
        base = got_q.size();
        fork
            begin
                for (int k = 0; k < 24; k++) send_beat(bp_word(100 + k));
            end
            begin
                for (int c = 0; c < 150; c++) begin
                    s1o_if.rdy = 1'($urandom_range(0, 1));
                    tick(1);
                end
                s1o_if.rdy = 1'b1;
            end
        join
        wait_out("rnd_wait", base + 24);
        tick(6);
        check("rnd_count", 128'(got_q.size() - base), 128'(24));
        for (int k = 0; k < 24; k++)
            check($sformatf("rnd_beat%0d", k), got_q[base+k],
                  exp_word(32'(16 + k), 32'(100 + k), 32'(3 * (100 + k))));

        // ---------------- mode change in the middle of a block ----------------
        base    = got_q.size();
        mode    = 2'd2;
        blk_len = 16'd3;
        send_beat(D_BEAT);
        mode    = 2'd1;
        blk_len = 16'd7;
        send_beat(D_BEAT);
        send_beat(D_BEAT);
        send_beat(D_BEAT);
        wait_out("mchg_wait", base + 2);
        tick(8);
        check("mchg_count", 128'(got_q.size() - base), 128'(2));
        check("mchg_reduce", got_q[base],   exp_word(32'd40, 32'd6, 32'h7E));
        check("mchg_dot",    got_q[base+1], exp_word(32'd41, 32'd6, 32'h2A));

        // ---------------- reset in ACCUM with a non-empty FIFO ----------------
        s1o_if.rdy = 1'b0;
        mode       = 2'd1;
        for (int i = 0; i < 5; i++) send_beat(D_BEAT);
        tick(4);
        check("mrst_level5", 128'(fifo_level), 128'(5));
        mode    = 2'd2;
        blk_len = 16'd4;
        send_beat(D_BEAT);
        tick(4);
        check("mrst_accum_busy", 128'(busy), 128'(1));
        do_reset();
        check("mrst_s1o_valid", 128'(s1o_if.valid), 128'(0));
        check("mrst_level",     128'(fifo_level),   128'(0));
        check("mrst_busy",      128'(busy),         128'(0));
        check("mrst_s1i_rdy",   128'(s1i_if.rdy),   128'(1));
        base       = got_q.size();
        s1o_if.rdy = 1'b1;
        mode       = 2'd1;
        send_beat(D_BEAT);
        wait_out("mrst_wait", base + 1);
        tick(8);
        check("mrst_count", 128'(got_q.size() - base), 128'(1));
        check("mrst_beat",  got_q[base], exp_word(32'd0, 32'd6, 32'h2A));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
